// File: rtl/multi_digit_counter_if.sv
// ============================================================================
// Module      : multi_digit_counter_if
// Description : Control/status bundle for the cascaded multi-digit counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multi_digit_counter_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 4
);
  logic                      load;
  logic [DIGITS*WIDTH-1:0]   start_count;
  logic                      start;
  logic                      stop;
  logic                      tick;
  logic                      up;
  logic [DIGITS*WIDTH-1:0]   count;
  logic                      term_count;
  logic                      running;
  logic                      done;
  logic                      done_pulse;

  modport master (
    output load, start_count, start, stop, tick, up,
    input  count, term_count, running, done, done_pulse
  );

  modport slave (
    input  load, start_count, start, stop, tick, up,
    output count, term_count, running, done, done_pulse
  );
endinterface

`default_nettype wire

// File: rtl/multi_digit_counter.sv
// ============================================================================
// Module      : multi_digit_counter
// Description : Cascaded per-digit up/down counter with run/pause/done control.
//               Optional build macro: MULTI_DIGIT_COUNTER_AUTO_RELOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_digit_counter #(
  parameter int                         DIGITS  = 4,
  parameter int                         WIDTH   = 4,
  parameter logic [DIGITS*WIDTH-1:0]    MAX_VEC = 16'h5959
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  multi_digit_counter_if.slave     bus
);

  localparam int                c_VW   = DIGITS * WIDTH;
  localparam logic [WIDTH-1:0]  c_ONE  = WIDTH'(1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_PAUSE = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [c_VW-1:0]  r_count;
  logic             r_done_pulse;
`ifdef MULTI_DIGIT_COUNTER_AUTO_RELOAD_EN
  logic [c_VW-1:0]  r_reload;
`endif

  logic [c_VW-1:0]  w_clamped;
  logic [c_VW-1:0]  w_stepped;
  logic             w_carry;
  logic             w_term_now;
  logic             w_term_next;
  logic             w_start_ok;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_clamp
      localparam logic [WIDTH-1:0] c_DMAX = MAX_VEC[g*WIDTH +: WIDTH];
      assign w_clamped[g*WIDTH +: WIDTH] =
        (bus.start_count[g*WIDTH +: WIDTH] > c_DMAX) ? c_DMAX
                                                     : bus.start_count[g*WIDTH +: WIDTH];
    end
  endgenerate

  // Carry/borrow ripples through every digit within one cycle.
  always_comb begin
    w_stepped = r_count;
    w_carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (bus.up) begin
          if (r_count[i*WIDTH +: WIDTH] == MAX_VEC[i*WIDTH +: WIDTH]) begin
            w_stepped[i*WIDTH +: WIDTH] = '0;
          end else begin
            w_stepped[i*WIDTH +: WIDTH] = r_count[i*WIDTH +: WIDTH] + c_ONE;
            w_carry = 1'b0;
          end
        end else begin
          if (r_count[i*WIDTH +: WIDTH] == '0) begin
            w_stepped[i*WIDTH +: WIDTH] = MAX_VEC[i*WIDTH +: WIDTH];
          end else begin
            w_stepped[i*WIDTH +: WIDTH] = r_count[i*WIDTH +: WIDTH] - c_ONE;
            w_carry = 1'b0;
          end
        end
      end
    end
  end

  assign w_term_now  = bus.up ? (r_count == MAX_VEC)   : (r_count == '0);
  assign w_term_next = bus.up ? (w_stepped == MAX_VEC) : (w_stepped == '0);
  assign w_start_ok  = (r_state == c_IDLE) || (r_state == c_PAUSE);

  // Commands are mutually exclusive by priority: load, stop, start, tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_IDLE;
      r_count      <= '0;
      r_done_pulse <= 1'b0;
`ifdef MULTI_DIGIT_COUNTER_AUTO_RELOAD_EN
      r_reload     <= '0;
`endif
    end else begin
      r_done_pulse <= 1'b0;
      if (bus.load) begin
        r_count <= w_clamped;
        r_state <= c_IDLE;
`ifdef MULTI_DIGIT_COUNTER_AUTO_RELOAD_EN
        r_reload <= w_clamped;
`endif
      end else if (bus.stop) begin
        if (r_state == c_RUN) begin
          r_state <= c_PAUSE;
        end
      end else if (bus.start && w_start_ok) begin
        if (w_term_now) begin
          r_state      <= c_DONE;
          r_done_pulse <= 1'b1;
        end else begin
          r_state <= c_RUN;
        end
      end else if (bus.tick && (r_state == c_RUN)) begin
        if (w_term_next) begin
          r_done_pulse <= 1'b1;
`ifdef MULTI_DIGIT_COUNTER_AUTO_RELOAD_EN
          r_count <= r_reload;
`else
          r_count <= w_stepped;
          r_state <= c_DONE;
`endif
        end else begin
          r_count <= w_stepped;
        end
      end
    end
  end

  assign bus.count      = r_count;
  assign bus.term_count = w_term_now;
  assign bus.running    = (r_state == c_RUN);
  assign bus.done       = (r_state == c_DONE);
  assign bus.done_pulse = r_done_pulse;

endmodule

`default_nettype wire

// File: tb/tb_multi_digit_counter.sv
// ============================================================================
// Module      : tb_multi_digit_counter
// Description : Directed and randomized checks against a mixed-radix model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_digit_counter;

  localparam int              DIGITS  = 4;
  localparam int              WIDTH   = 4;
  localparam int              VW      = DIGITS * WIDTH;
  localparam logic [VW-1:0]   MAX_VEC = 16'h5959;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multi_digit_counter_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

  multi_digit_counter #(
    .DIGITS  (DIGITS),
    .WIDTH   (WIDTH),
    .MAX_VEC (MAX_VEC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: the count as one integer in a mixed-radix number system.
  int m_val, m_reload, m_state, m_mod;
  bit m_pulse;

  function automatic int digit_max(input int i);
    logic [VW-1:0] mv;
    mv = MAX_VEC;
    return int'(mv[i*WIDTH +: WIDTH]);
  endfunction

  function automatic int to_val(input logic [VW-1:0] v);
    int acc = 0;
    int d;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(v[i*WIDTH +: WIDTH]);
      if (d > digit_max(i)) d = digit_max(i);
      acc = acc * (digit_max(i) + 1) + d;
    end
    return acc;
  endfunction

  function automatic logic [VW-1:0] to_vec(input int v);
    logic [VW-1:0] r = '0;
    int rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*WIDTH +: WIDTH] = WIDTH'(rem % (digit_max(i) + 1));
      rem = rem / (digit_max(i) + 1);
    end
    return r;
  endfunction

  function automatic bit at_end(input int v, input bit u);
    return u ? (v == m_mod - 1) : (v == 0);
  endfunction

  task automatic model_reset();
    m_val = 0; m_reload = 0; m_state = S_IDLE; m_pulse = 1'b0;
  endtask

  task automatic model_apply(input bit ld, input logic [VW-1:0] sc,
                             input bit st, input bit sp, input bit tk, input bit u);
    m_pulse = 1'b0;
    if (ld) begin
      m_val = to_val(sc); m_reload = m_val; m_state = S_IDLE;
    end else if (sp) begin
      if (m_state == S_RUN) m_state = S_PAUSE;
    end else if (st && (m_state == S_IDLE || m_state == S_PAUSE)) begin
      if (at_end(m_val, u)) begin m_state = S_DONE; m_pulse = 1'b1; end
      else m_state = S_RUN;
    end else if (tk && m_state == S_RUN) begin
      m_val = u ? (m_val + 1) % m_mod : (m_val + m_mod - 1) % m_mod;
      if (at_end(m_val, u)) begin
        m_pulse = 1'b1;
`ifdef MULTI_DIGIT_COUNTER_AUTO_RELOAD_EN
        m_val = m_reload;
`else
        m_state = S_DONE;
`endif
      end
    end
  endtask

  task automatic step(input bit ld, input logic [VW-1:0] sc,
                      input bit st, input bit sp, input bit tk, input bit u);
    bus.load = ld; bus.start_count = sc; bus.start = st;
    bus.stop = sp; bus.tick = tk; bus.up = u;
    @(posedge clk);
    #1;
    model_apply(ld, sc, st, sp, tk, u);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.load = 0; bus.start_count = '0; bus.start = 0;
    bus.stop = 0; bus.tick = 0; bus.up = 1;
    model_reset();
    #2;
    n_vec++;
    if ({bus.count, bus.running, bus.done, bus.done_pulse} !== {16'h0000, 3'b000}) begin
      n_err++;
      $display("FAIL reset_async count=%h r/d/p=%b%b%b want 0000 000",
               bus.count, bus.running, bus.done, bus.done_pulse);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.count, bus.running, bus.done, bus.done_pulse} !== {16'h0000, 3'b000}) begin
      n_err++;
      $display("FAIL reset_held count=%h r/d/p=%b%b%b want 0000 000",
               bus.count, bus.running, bus.done, bus.done_pulse);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_down_borrow();
    step(1, 16'h0100, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0);
    n_vec++;
    if (bus.count !== 16'h0059 || bus.running !== 1'b1) begin
      n_err++;
      $display("FAIL down_borrow count=%h running=%b want 0059 1", bus.count, bus.running);
    end
  endtask

  task automatic test_up_carry_done();
    step(1, 16'h0959, 0, 0, 0, 1);
    step(0, '0, 1, 0, 0, 1);
    step(0, '0, 0, 0, 1, 1);
    n_vec++;
    if (bus.count !== 16'h1000) begin
      n_err++; $display("FAIL up_carry count=%h want 1000", bus.count);
    end
    step(1, 16'h5958, 0, 0, 0, 1);
    step(0, '0, 1, 0, 0, 1);
    step(0, '0, 0, 0, 1, 1);
    n_vec++;
    if ({bus.count, bus.done, bus.done_pulse, bus.running} !== {16'h5959, 3'b110}) begin
      n_err++;
      $display("FAIL up_done count=%h d/p/r=%b%b%b want 5959 110",
               bus.count, bus.done, bus.done_pulse, bus.running);
    end
    step(0, '0, 0, 0, 1, 1);
    step(0, '0, 1, 0, 1, 1);
    step(0, '0, 0, 1, 1, 1);
    n_vec++;
    if ({bus.count, bus.done, bus.done_pulse, bus.running} !== {16'h5959, 3'b100}) begin
      n_err++;
      $display("FAIL done_sticky count=%h d/p/r=%b%b%b want 5959 100",
               bus.count, bus.done, bus.done_pulse, bus.running);
    end
  endtask

  task automatic test_pause();
    step(1, 16'h0003, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0);
    step(0, '0, 0, 0, 1, 0);
    step(0, '0, 0, 1, 0, 0);
    repeat (5) step(0, '0, 0, 0, 1, 0);
    n_vec++;
    if ({bus.count, bus.running, bus.done} !== {16'h0001, 2'b00}) begin
      n_err++;
      $display("FAIL pause_hold count=%h run/done=%b%b want 0001 00",
               bus.count, bus.running, bus.done);
    end
    step(0, '0, 1, 0, 1, 0);
    n_vec++;
    if (bus.count !== 16'h0001 || bus.running !== 1'b1) begin
      n_err++;
      $display("FAIL resume_tick_ignored count=%h running=%b want 0001 1", bus.count, bus.running);
    end
    step(0, '0, 0, 0, 1, 0);
    n_vec++;
    if ({bus.count, bus.done, bus.done_pulse} !== {16'h0000, 2'b11}) begin
      n_err++;
      $display("FAIL down_done count=%h done/pulse=%b%b want 0000 11",
               bus.count, bus.done, bus.done_pulse);
    end
  endtask

  task automatic test_clamp_term();
    step(1, 16'h7A9F, 0, 0, 0, 1);
    n_vec++;
    if (bus.count !== 16'h5959 || bus.term_count !== 1'b1) begin
      n_err++;
      $display("FAIL clamp count=%h term=%b want 5959 1", bus.count, bus.term_count);
    end
    bus.up = 1'b0;
    #1;
    n_vec++;
    if (bus.term_count !== 1'b0) begin
      n_err++; $display("FAIL term_comb term=%b want 0", bus.term_count);
    end
    step(1, 16'h0000, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    n_vec++;
    if ({bus.done, bus.done_pulse, bus.running} !== 3'b110) begin
      n_err++;
      $display("FAIL start_at_term d/p/r=%b%b%b want 110", bus.done, bus.done_pulse, bus.running);
    end
  endtask

  task automatic test_reset_midrun();
    step(1, 16'h0042, 0, 0, 0, 1);
    step(0, '0, 1, 0, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({bus.count, bus.running, bus.done_pulse} !== {16'h0000, 2'b00}) begin
      n_err++;
      $display("FAIL reset_midrun count=%h run/pulse=%b%b want 0000 00",
               bus.count, bus.running, bus.done_pulse);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(0, '0, 0, 0, 1, 1);
    n_vec++;
    if (bus.running !== 1'b0 || bus.count !== 16'h0000) begin
      n_err++;
      $display("FAIL no_resume running=%b count=%h want 0 0000", bus.running, bus.count);
    end
    step(0, '0, 1, 0, 1, 1);
    n_vec++;
    if (bus.count !== 16'h0000 || bus.running !== 1'b1) begin
      n_err++;
      $display("FAIL start_tick count=%h running=%b want 0000 1", bus.count, bus.running);
    end
  endtask

`ifdef MULTI_DIGIT_COUNTER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    step(1, 16'h0002, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0);
    step(0, '0, 0, 0, 1, 0);
    n_vec++;
    if ({bus.count, bus.running, bus.done_pulse, bus.done} !== {16'h0002, 3'b110}) begin
      n_err++;
      $display("FAIL auto_reload count=%h r/p/d=%b%b%b want 0002 110",
               bus.count, bus.running, bus.done_pulse, bus.done);
    end
  endtask
`endif

  task automatic test_random();
    logic [VW+3:0] exp_v, obs_v;
    logic [VW-1:0] sc;
    bit ld, st, sp, tk, u;
    u = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      ld = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 3))
        0:       sc = VW'($urandom);
        1:       sc = to_vec(int'($urandom_range(0, 5)));
        2:       sc = to_vec(m_mod - 1 - int'($urandom_range(0, 5)));
        default: sc = to_vec(int'($urandom_range(0, m_mod - 1)));
      endcase
      st = ($urandom_range(0, 99) < 15);
      sp = ($urandom_range(0, 99) < 4);
      tk = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 5) u = ~u;
      step(ld, sc, st, sp, tk, u);
      exp_v = {to_vec(m_val), at_end(m_val, u), (m_state == S_RUN),
               (m_state == S_DONE), m_pulse};
      obs_v = {bus.count, bus.term_count, bus.running, bus.done, bus.done_pulse};
      n_vec++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL random[%0d] {count,term,run,done,pulse} got=%h want=%h", i, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    m_mod = 1;
    for (int i = 0; i < DIGITS; i++) m_mod = m_mod * (digit_max(i) + 1);
    test_reset();
    test_down_borrow();
`ifdef MULTI_DIGIT_COUNTER_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_up_carry_done();
    test_pause();
`endif
    test_clamp_term();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_digit_counter.md
MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of cascaded digits, range 1..8.
REQ-002 SHALL have parameter WIDTH, default 4: bits per digit.
REQ-003 SHALL have parameter MAX_VEC, width DIGITS*WIDTH, default 16'h5959: packed per-digit maximum, digit 0 in LSBs, each field at most 2^WIDTH-1.
REQ-004 SHALL have port clk, input, 1: the single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port load, input, 1: synchronous load of start_count.
REQ-007 SHALL have port start_count, input, DIGITS*WIDTH: packed load value.
REQ-008 SHALL have port start, input, 1: run request.
REQ-009 SHALL have port stop, input, 1: pause request.
REQ-010 SHALL have port tick, input, 1: single-cycle count-enable strobe.
REQ-011 SHALL have port up, input, 1: direction; 1 counts up, 0 counts down.
REQ-012 SHALL have port count, output, DIGITS*WIDTH: registered packed digits.
REQ-013 SHALL have port term_count, output, 1: combinational; count == MAX_VEC when up=1, count == 0 when up=0.
REQ-014 SHALL have port running, output, 1: high in state RUN.
REQ-015 SHALL have port done, output, 1: high in state DONE.
REQ-016 SHALL have port done_pulse, output, 1: registered single-cycle terminal event.

Function
REQ-017 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-018 SHALL apply priority load > stop > start > tick.
REQ-019 load in any state SHALL set count to start_count, each digit clamped to its MAX_VEC field if larger, copy the clamped value into an internal reload register, and enter IDLE.
REQ-020 start in IDLE or PAUSE SHALL enter RUN; if term_count is already high, it SHALL instead enter DONE with done_pulse high for one cycle.
REQ-021 stop in RUN SHALL enter PAUSE, holding count.
REQ-022 start or stop in DONE SHALL be ignored; only load or reset exits DONE.
REQ-023 tick SHALL change count only in RUN; a tick in the same cycle as a start accepted from IDLE or PAUSE SHALL be ignored.
REQ-024 On a tick with up=1, digit 0 SHALL increment; a digit at its MAX SHALL wrap to 0 and carry into the next digit.
REQ-025 On a tick with up=0, digit 0 SHALL decrement; a digit at 0 SHALL wrap to its MAX and borrow from the next digit.
REQ-026 Carry or borrow SHALL ripple through all digits in one cycle, so the latency from tick to the updated count is 1 clock.
REQ-027 On the edge where count becomes the terminal value for the current up, the block SHALL enter DONE and assert done_pulse for exactly that following cycle.
REQ-028 A change of up during RUN SHALL take effect at the next tick; no count change occurs without a tick.
REQ-029 done_pulse SHALL be low in every cycle other than those defined in REQ-020 and REQ-027.

Reset
REQ-030 While reset_n is low, and immediately with no clock required, count, reload register, running, done and done_pulse SHALL be 0 and the state SHALL be IDLE.
REQ-031 Deassertion of reset_n mid-run SHALL NOT resume the previous run; the block SHALL stay in IDLE until start.

Configuration
REQ-032 With macro MULTI_DIGIT_COUNTER_AUTO_RELOAD_EN defined, reaching terminal in RUN SHALL reload count from the reload register on the same edge, stay in RUN and assert done_pulse for one cycle, and done SHALL never assert via REQ-027.
REQ-033 Without MULTI_DIGIT_COUNTER_AUTO_RELOAD_EN, behaviour SHALL be exactly as specified in REQ-027, and no reload-on-terminal logic SHALL exist.

Verification (DIGITS=4, WIDTH=4, MAX_VEC=16'h5959)
REQ-034 load 16'h0100, up=0, start, 1 tick -> count=16'h0059, running=1.
REQ-035 load 16'h0959, up=1, start, 1 tick -> count=16'h1000; load 16'h5958, 1 tick -> count=16'h5959, done=1, done_pulse high 1 cycle, further ticks leave count unchanged.
REQ-036 load 16'h0003, up=0, start, 2 ticks, stop, 5 ticks -> count=16'h0001, PAUSE; start, 1 tick -> 16'h0000, DONE.
REQ-037 load 16'h7A9F -> count=16'h5959 (clamped); load 16'h0000, up=0, start -> DONE next cycle with done_pulse.
REQ-038 reset_n low mid-RUN at count 16'h0042 -> count=0, running=0 with no clock edge; start plus tick in the same cycle -> count unchanged.
REQ-039 With AUTO_RELOAD_EN defined: load 16'h0002, up=0, start, 2 ticks -> count=16'h0002, running=1, done_pulse one cycle, done=0.
